// File: rtl/raw8_axi4s_packer.sv
// Purpose : packs one RAW8 pixel per cycle into DATA_WIDTH words and streams them out over AXI4-Stream.
// Latency : a word completed (or flushed) in cycle t is presented on axi4s_mvalid_o/axi4s_mdata_o in cycle t+1.
// Backpr. : none on the pixel side; words queue in a FIFO_DEPTH FIFO, a push into a full FIFO is dropped and overflow_o sticks.
//
// Ports:
//   axi4s_mclk_i / axi4s_rst_i       clock, asynchronous active-high reset
//   pix_valid_i, pix_i, line_end_i   pixel input (no backpressure), line-end flush pulse
//   axi4s_mvalid_o/_mready_i/_mdata_o AXI4-Stream master
//   overflow_o                       sticky dropped-word flag
//   fifo_level_o                     words currently buffered (0..FIFO_DEPTH)
//   word_cnt_o                       only with RAW8_PACK_WORD_CNT_EN: handshaked words, wraps at 2^32
//
// Optional feature macro: RAW8_PACK_WORD_CNT_EN

// Small generic synchronous FIFO: registered storage, head shown combinationally,
// zeros on the head when empty. A push while full is ignored unless a pop frees
// the slot in the same cycle.
module raw8_pack_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign level    = level_q;
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    do_push  = push_vld && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module raw8_axi4s_packer #(
  parameter int DATA_WIDTH = 48,
  parameter int PIX_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          axi4s_mclk_i,
  input  logic                          axi4s_rst_i,
  input  logic                          pix_valid_i,
  input  logic [PIX_WIDTH-1:0]          pix_i,
  input  logic                          line_end_i,
  output logic                          axi4s_mvalid_o,
  input  logic                          axi4s_mready_i,
  output logic [DATA_WIDTH-1:0]         axi4s_mdata_o,
  output logic                          overflow_o,
`ifdef RAW8_PACK_WORD_CNT_EN
  output logic [31:0]                   word_cnt_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  localparam int PPW = DATA_WIDTH / PIX_WIDTH;
  localparam int CW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(PPW - 1);

  typedef enum logic {EMPTY, FILL} pack_state_e;

  pack_state_e           state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] word_w;
  logic                  push, last_pix, flush, pop;
  logic                  fifo_full, fifo_empty;

  // Assembly: merge the incoming pixel into its slot, then decide whether the
  // word leaves this cycle. A completing pixel with line_end gives one push only.
  always_comb begin
    word_w = asm_q;
    for (int k = 0; k < PPW; k++) begin
      if (pix_valid_i && (count_q == CW'(k))) word_w[k*PIX_WIDTH +: PIX_WIDTH] = pix_i;
    end
    last_pix = pix_valid_i && (count_q == LAST);
    flush    = line_end_i && ((state_q == FILL) || pix_valid_i);
    push     = last_pix || flush;

    asm_d   = asm_q;
    count_d = count_q;
    if (push) begin
      // Clearing here is what zero-fills unused slots of the next flushed word.
      asm_d   = '0;
      count_d = '0;
    end else if (pix_valid_i) begin
      asm_d   = word_w;
      count_d = count_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (pix_valid_i && !push) state_d = FILL;
      FILL:    if (push) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge axi4s_mclk_i or posedge axi4s_rst_i) begin
    if (axi4s_rst_i) begin
      state_q    <= EMPTY;
      count_q    <= '0;
      asm_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_d;
    end
  end

  assign pop        = axi4s_mvalid_o && axi4s_mready_i;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  raw8_pack_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (axi4s_mclk_i),
    .rst      (axi4s_rst_i),
    .push_vld (push),
    .push_dat (word_w),
    .pop      (pop),
    .head_dat (axi4s_mdata_o),
    .level    (fifo_level_o),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign axi4s_mvalid_o = !fifo_empty;
  assign overflow_o     = overflow_q;

`ifdef RAW8_PACK_WORD_CNT_EN
  logic [31:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q + 32'(pop);
  end

  always_ff @(posedge axi4s_mclk_i or posedge axi4s_rst_i) begin
    if (axi4s_rst_i) word_cnt_q <= '0;
    else             word_cnt_q <= word_cnt_d;
  end

  assign word_cnt_o = word_cnt_q;
`endif
endmodule

// File: tb/tb_raw8_axi4s_packer.sv
module tb_raw8_axi4s_packer;
  logic        clk;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pix;
  logic        line_end;
  logic        mvalid;
  logic        mready;
  logic [47:0] mdata;
  logic        overflow;
  logic [2:0]  level;
`ifdef RAW8_PACK_WORD_CNT_EN
  logic [31:0] word_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int beats = 0;
  int beats_rst = 0;
  logic [47:0] exp_q[$];

  raw8_axi4s_packer dut (
    .axi4s_mclk_i   (clk),
    .axi4s_rst_i    (rst),
    .pix_valid_i    (pix_valid),
    .pix_i          (pix),
    .line_end_i     (line_end),
    .axi4s_mvalid_o (mvalid),
    .axi4s_mready_i (mready),
    .axi4s_mdata_o  (mdata),
    .overflow_o     (overflow),
`ifdef RAW8_PACK_WORD_CNT_EN
    .word_cnt_o     (word_cnt),
`endif
    .fifo_level_o   (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-computed words for pixel values 1..30 packed six per word.
  logic [47:0] seq_w [5] = '{48'h060504030201, 48'h0C0B0A090807, 48'h1211100F0E0D,
                             48'h181716151413, 48'h1E1D1C1B1A19};
  // Words for pixel value 16*j+k, j=1..6, k=0..5.
  logic [47:0] tog_w [6] = '{48'h151413121110, 48'h252423222120, 48'h353433323130,
                             48'h454443424140, 48'h555453525150, 48'h656463626160};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] p, input logic le);
    pix_valid = 1'b1;
    pix       = p;
    line_end  = le;
    tick();
    pix_valid = 1'b0;
    line_end  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || mvalid); i++) tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_valid_low", 64'(mvalid), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Monitor: compares each handshaked beat against the scoreboard and checks
  // that a stalled beat holds its data until accepted.
  initial begin
    logic        hold;
    logic [47:0] held;
    logic [47:0] e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        beats_rst = 0;
      end else begin
        if (hold) begin
          checks++;
          if (!mvalid || mdata !== held) begin
            errors++;
            $display("FAIL stall_stable: valid=%0b data=0x%0h, expected valid=1 data=0x%0h", mvalid, mdata, held);
          end
        end
        if (mvalid && mready) begin
          beats++;
          beats_rst++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", mdata);
          end else begin
            e = exp_q.pop_front();
            if (mdata !== e) begin
              errors++;
              $display("FAIL beat_data: got 0x%0h, expected 0x%0h", mdata, e);
            end
          end
          hold = 1'b0;
        end else if (mvalid) begin
          hold = 1'b1;
          held = mdata;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin
    int b;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix       = '0;
    line_end  = 1'b0;
    mready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(mvalid), 64'd0);
    check("rst_data", 64'(mdata), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick();

    // Basic packing and one-cycle latency.
    for (int k = 1; k <= 5; k++) drive(8'(k), 1'b0);
    exp_q.push_back(48'h060504030201);
    check("lat_valid_before", 64'(mvalid), 64'd0);
    drive(8'h06, 1'b0);
    check("lat_valid_after", 64'(mvalid), 64'd1);
    check("lat_data", 64'(mdata), 64'h060504030201);
    drain();

    // Partial word flushed by line_end.
    drive(8'hAA, 1'b0);
    drive(8'hBB, 1'b0);
    drive(8'hCC, 1'b0);
    check("partial_no_valid", 64'(mvalid), 64'd0);
    exp_q.push_back(48'h000000CCBBAA);
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    check("flush_valid", 64'(mvalid), 64'd1);
    drain();

    // line_end with nothing pending.
    b = beats;
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    repeat (3) tick();
    check("empty_flush_beats", 64'(beats - b), 64'd0);
    check("empty_flush_level", 64'(level), 64'd0);

    // line_end together with the completing pixel: a single push.
    b = beats;
    for (int k = 1; k <= 5; k++) drive(8'(k), 1'b0);
    exp_q.push_back(48'h060504030201);
    drive(8'h06, 1'b1);
    drain();
    check("complete_flush_beats", 64'(beats - b), 64'd1);

    // line_end together with a mid-word pixel: pixel is included.
    drive(8'h11, 1'b0);
    drive(8'h22, 1'b0);
    exp_q.push_back(48'h000000332211);
    drive(8'h33, 1'b1);
    drain();

    // Overflow: 5 words into a 4-deep FIFO with ready low.
    mready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(seq_w[i]);
    for (int k = 1; k <= 24; k++) drive(8'(k), 1'b0);
    check("ovf_level_full", 64'(level), 64'd4);
    check("ovf_not_yet", 64'(overflow), 64'd0);
    for (int k = 25; k <= 30; k++) drive(8'(k), 1'b0);
    check("ovf_level_after", 64'(level), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);
    b = beats;
    mready = 1'b1;
    drain();
    check("ovf_drain_beats", 64'(beats - b), 64'd4);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    check("post_reset_overflow", 64'(overflow), 64'd0);
    mready = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(seq_w[i]);
    for (int k = 1; k <= 29; k++) drive(8'(k), 1'b0);
    check("pp_level_full", 64'(level), 64'd4);
    mready = 1'b1;
    drive(8'd30, 1'b0);
    mready = 1'b0;
    check("pp_level_same", 64'(level), 64'd4);
    check("pp_no_overflow", 64'(overflow), 64'd0);
    mready = 1'b1;
    drain();
    check("pp_overflow_final", 64'(overflow), 64'd0);

    // Ready toggling each cycle under continuous pixels.
    do_reset();
    b = beats;
    for (int j = 1; j <= 6; j++) begin
      exp_q.push_back(tog_w[j-1]);
      for (int k = 0; k < 6; k++) begin
        mready = ~mready;
        drive(8'(16*j + k), 1'b0);
      end
    end
    mready = 1'b1;
    drain();
    check("tog_beats", 64'(beats - b), 64'd6);
`ifdef RAW8_PACK_WORD_CNT_EN
    check("word_cnt", 64'(word_cnt), 64'(beats_rst));
    check("word_cnt_abs", 64'(word_cnt), 64'd6);
`endif

    // Reset mid-word with two words buffered.
    mready = 1'b0;
    exp_q.push_back(seq_w[0]);
    exp_q.push_back(seq_w[1]);
    for (int k = 1; k <= 15; k++) drive(8'(k), 1'b0);
    check("mid_level", 64'(level), 64'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(mvalid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_data", 64'(mdata), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    mready = 1'b1;
    tick();
    exp_q.push_back(48'hA6A5A4A3A2A1);
    for (int k = 1; k <= 6; k++) drive(8'hA0 + 8'(k), 1'b0);
    check("clean_word_valid", 64'(mvalid), 64'd1);
    check("clean_word_data", 64'(mdata), 64'hA6A5A4A3A2A1);
    drain();
    check("final_overflow", 64'(overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
